// File: rtl/posit_raw_pkg.sv
// posit_raw_pkg: raw posit field layout, widths and packed views shared by the adder pipeline.
package posit_raw_pkg;

  localparam int NBITS   = 32;
  localparam int ES      = 3;
  localparam int FRAC_W  = 26;
  localparam int SCALE_W = $clog2((NBITS - 2) * (1 << ES) + (1 << ES)) + 1;

  typedef struct packed {
    logic                      sgn;
    logic signed [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]         frac;
    logic                      inf;
    logic                      zero;
  } raw_t;

  typedef struct packed {
    logic                    sgn;
    logic signed [SCALE_W:0] scale;
    logic [FRAC_W+1:0]       frac;
    logic                    inf;
    logic                    zero;
  } raw_sum_t;

  localparam int ZERO_B = 0;
  localparam int INF_B  = 1;
  localparam int FRAC_B = 2;

  function automatic int raw_w(input int sw, input int fw);
    return sw + fw + 3;
  endfunction

  function automatic int sum_w(input int sw, input int fw);
    return sw + fw + 6;
  endfunction

  function automatic int scale_b(input int fw);
    return fw + 2;
  endfunction

  function automatic int sgn_b(input int sw, input int fw);
    return sw + fw + 2;
  endfunction

endpackage

// File: rtl/posit_lzc.sv
// posit_lzc: leading-one position of an N-bit word plus an all-zero flag.
module posit_lzc #(
  parameter  int N = 30,
  localparam int L = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] x,
  output logic [L-1:0] pos,
  output logic         zero
);

  always_comb begin
    pos = '0;
    for (int i = 0; i < N; i++) pos = x[i] ? L'(i) : pos;
  end

  assign zero = ~|x;

endmodule

// File: rtl/posit_add_raw_pipe.sv
// posit_add_raw_pipe: pipelined raw posit add/sub, valid/ready backpressure, latency 4.
// Define POSIT_ADD_STICKY_EN to build the alignment sticky bit; otherwise out_sticky is 0.
module posit_add_raw_pipe
  import posit_raw_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int ES      = 3,
  parameter int SCALE_W = 9,
  parameter int FRAC_W  = 26,
  parameter int TAG_W   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [raw_w(SCALE_W, FRAC_W)-1:0] in_a,
  input  logic [raw_w(SCALE_W, FRAC_W)-1:0] in_b,
  input  logic                              in_sub,
  input  logic [TAG_W-1:0]                  in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [sum_w(SCALE_W, FRAC_W)-1:0] out_sum,
  output logic [TAG_W-1:0]                  out_tag,
  output logic                              out_sticky
);

  localparam int RW   = raw_w(SCALE_W, FRAC_W);
  localparam int OW   = sum_w(SCALE_W, FRAC_W);
  localparam int W    = FRAC_W + 4;
  localparam int L    = $clog2(W);
  localparam int DW   = SCALE_W + 1;
  localparam int SC_B = scale_b(FRAC_W);
  localparam int SG_B = sgn_b(SCALE_W, FRAC_W);
  localparam int SCALE_MAX = (NBITS - 2) * (1 << ES) + (1 << ES) - 1;

  if (SCALE_MAX > (1 << (SCALE_W - 1)) - 1) begin : g_bad_scale_w
    $error("SCALE_W cannot hold the posit scale range");
  end

  assign in_ready = ~(out_valid & ~out_ready);

  logic              v0, sub0;
  logic [RW-1:0]     a0, b0;
  logic [TAG_W-1:0]  tag0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0   <= 1'b0;
      a0   <= '0;
      b0   <= '0;
      sub0 <= 1'b0;
      tag0 <= '0;
    end else if (in_ready) begin
      v0   <= in_valid;
      a0   <= in_a;
      b0   <= in_b;
      sub0 <= in_sub;
      tag0 <= in_tag;
    end
  end

  logic                a_z, b_z, a_s, b_s, a_hi;
  logic [SCALE_W-1:0]  a_sc, b_sc;
  logic [DW-1:0]       a_x, b_x;
  logic [FRAC_W-1:0]   a_fr, b_fr;

  // zero operands are scrubbed and always rank as the smaller magnitude
  always_comb begin
    a_z  = a0[ZERO_B];
    b_z  = b0[ZERO_B];
    a_s  = ~a_z & a0[SG_B];
    b_s  = ~b_z & (b0[SG_B] ^ sub0);
    a_sc = a_z ? '0 : a0[SC_B +: SCALE_W];
    b_sc = b_z ? '0 : b0[SC_B +: SCALE_W];
    a_fr = a_z ? '0 : a0[FRAC_B +: FRAC_W];
    b_fr = b_z ? '0 : b0[FRAC_B +: FRAC_W];
    a_x  = {a_sc[SCALE_W-1], a_sc};
    b_x  = {b_sc[SCALE_W-1], b_sc};
    a_hi = b_z | (~a_z & (($signed(a_sc) > $signed(b_sc)) | ((a_sc == b_sc) & (a_fr >= b_fr))));
  end

  logic               v1, hs1, hz1, lz1, es1, inf1;
  logic [SCALE_W-1:0] hsc1;
  logic [FRAC_W-1:0]  hfr1, lfr1;
  logic [DW-1:0]      d1;
  logic [TAG_W-1:0]   tag1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      hs1  <= 1'b0;
      hz1  <= 1'b0;
      lz1  <= 1'b0;
      es1  <= 1'b0;
      inf1 <= 1'b0;
      hsc1 <= '0;
      hfr1 <= '0;
      lfr1 <= '0;
      d1   <= '0;
      tag1 <= '0;
    end else if (in_ready) begin
      v1   <= v0;
      hs1  <= a_hi ? a_s : b_s;
      hz1  <= a_hi ? a_z : b_z;
      lz1  <= a_hi ? b_z : a_z;
      es1  <= a_s ^ b_s;
      inf1 <= a0[INF_B] | b0[INF_B];
      hsc1 <= a_hi ? a_sc : b_sc;
      hfr1 <= a_hi ? a_fr : b_fr;
      lfr1 <= a_hi ? b_fr : a_fr;
      d1   <= a_hi ? a_x - b_x : b_x - a_x;
      tag1 <= tag0;
    end
  end

  logic [W-1:0] hm, lm, lsh, sum1;
  logic         big;

  assign hm   = {1'b0, ~hz1, hfr1, 2'b00};
  assign lm   = {1'b0, ~lz1, lfr1, 2'b00};
  assign big  = d1 >= DW'(W);
  assign lsh  = big ? '0 : lm >> d1;
  assign sum1 = es1 ? hm - lsh : hm + lsh;

  logic               v2, hs2, inf2;
  logic [W-1:0]       sum2;
  logic [SCALE_W-1:0] hsc2;
  logic [TAG_W-1:0]   tag2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      hs2  <= 1'b0;
      inf2 <= 1'b0;
      sum2 <= '0;
      hsc2 <= '0;
      tag2 <= '0;
    end else if (in_ready) begin
      v2   <= v1;
      hs2  <= hs1;
      inf2 <= inf1;
      sum2 <= sum1;
      hsc2 <= hsc1;
      tag2 <= tag1;
    end
  end

  logic [L-1:0]  p2;
  logic          z2;
  logic [DW-1:0] sc2;

  posit_lzc #(.N(W)) u_lzc (
    .x    (sum2),
    .pos  (p2),
    .zero (z2)
  );

  // the hidden bit sits at FRAC_W+2, so the scale moves by the leading-one offset from it
  assign sc2 = {hsc2[SCALE_W-1], hsc2} + DW'(p2) - DW'(FRAC_W + 2);

  logic             v3, hs3, inf3, z3;
  logic [W-1:0]     sum3;
  logic [L-1:0]     sh3;
  logic [DW-1:0]    sc3;
  logic [TAG_W-1:0] tag3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      hs3  <= 1'b0;
      inf3 <= 1'b0;
      z3   <= 1'b0;
      sum3 <= '0;
      sh3  <= '0;
      sc3  <= '0;
      tag3 <= '0;
    end else if (in_ready) begin
      v3   <= v2;
      hs3  <= hs2;
      inf3 <= inf2;
      z3   <= z2;
      sum3 <= sum2;
      sh3  <= L'(W - 1) - p2;
      sc3  <= sc2;
      tag3 <= tag2;
    end
  end

  logic [FRAC_W+1:0] nfr;

  assign nfr = (FRAC_W + 2)'((sum3 << sh3) >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_tag   <= '0;
    end else if (in_ready) begin
      out_valid <= v3;
      out_sum   <= inf3 ? OW'(2) : z3 ? OW'(1) : {hs3, sc3, nfr, 2'b00};
      out_tag   <= tag3;
    end
  end

`ifdef POSIT_ADD_STICKY_EN
  logic st1, st2, st3;

  assign st1 = big ? |lm : |(lm & ~({W{1'b1}} << d1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st2        <= 1'b0;
      st3        <= 1'b0;
      out_sticky <= 1'b0;
    end else if (in_ready) begin
      st2        <= st1;
      st3        <= st2;
      out_sticky <= st3 & ~inf3;
    end
  end
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: doc/posit_add_raw_pipe.md
Name: posit_add_raw_pipe

Overview:
- Next-generation raw posit adder/subtractor, parametrised in posit width, ES and fraction width.
- Operates on serialized raw posits `{sgn, scale, fraction, inf, zero}` and produces an unrounded raw sum for the downstream normalise/round stage.
- Adds what the fixed es3 adder lacks: a valid/ready handshake with backpressure, an add/subtract mode bit, signed scale compare and a passthrough tag.
- 4-stage pipeline, latency 4.

Parameters:
- NBITS, 32, posit width; sets the scale range.
- ES, 3, exponent bits.
- SCALE_W, 9, input scale width, two's complement (must hold ±((NBITS-2)·2^ES + 2^ES - 1)).
- FRAC_W, 26, input fraction width, hidden bit excluded.
- TAG_W, 4, sideband tag width, passed through unchanged.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts this cycle
- in_a  in  SCALE_W+FRAC_W+3  raw operand A `{sgn, scale, frac, inf, zero}`
- in_b  in  SCALE_W+FRAC_W+3  raw operand B
- in_sub  in  1  1 = A−B, 0 = A+B
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_sum  out  SCALE_W+FRAC_W+6  `{sgn, scale[SCALE_W+1], frac[FRAC_W+2], inf, zero}`
- out_tag  out  TAG_W  tag of out_sum
- out_sticky  out  1  OR of bits shifted out during alignment (see Optional Feature)

Behaviour:
- Reset: rst_n low asynchronously clears all stage valid bits and all data registers. out_valid=0, out_sum=0, out_tag=0, out_sticky=0. In-flight operations are discarded, not completed. in_ready is 1 one cycle after reset deasserts.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - Transfer on in_valid & in_ready. All four stages advance together when stall=0 and freeze when stall=1. Bubbles are not collapsed.
  - out_sum and out_tag stay stable while out_valid=1 and out_ready=0.
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+4 when no stall occurs. Throughput is 1 per cycle. Order is preserved.
- S0 (register inputs, compare/swap):
  - An operand with zero=1 has its sgn, scale and frac forced to 0.
  - B.sgn is inverted when in_sub=1.
  - eff_sub = A.sgn ^ B.sgn'.
  - Magnitude compare uses signed scale first, then unsigned frac. A is hi on ties.
  - d = hi.scale − low.scale, unsigned.
- S1 (align, add): working width W = FRAC_W+4, laid out as `{carry, hidden=~zero, frac, 2 guard}`.
  - low is right-shifted by d; d ≥ W yields 0.
  - sum = hi ± low according to eff_sub.
- S2 (LZC, scale):
  - p = leading-one position of sum. The hidden position is FRAC_W+2.
  - scale_out = hi.scale + (p − (FRAC_W+2)), sign-extended to SCALE_W+1.
  - A sum of 0 gives zero=1, sgn=0, scale=0.
- S3 (normalise): sum is left-shifted so the leading one drops out; the next FRAC_W+2 bits form frac. out_sgn = hi.sgn.
- Specials:
  - Either inf → inf=1, zero=0, sgn=0, scale=0, frac=0.
  - Both zero → zero=1.
  - One zero → result is the other operand unchanged (frac guard bits 00).
  - No rounding is performed.

Optional Feature:
- Macro: POSIT_ADD_STICKY_EN.
- Defined: S1 ORs every bit lost by the alignment shift (all of low's bits when d ≥ W) into a sticky bit. The sticky bit travels with the stage and drives out_sticky.
- Undefined: no sticky logic is built and out_sticky is tied to 0. The port is present in both builds.

Decomposition:
- Shared package posit_raw_pkg: raw_t and raw_sum_t packed structs, parametrised through localparams derived from NBITS/ES/FRAC_W; the width functions raw_w() and sum_w(); the serialized field-offset constants.
- Sub-module posit_lzc: parametrised leading-one detector (N in, clog2(N) out, plus an all-zero flag), instantiated in S2.

Test Plan (NBITS=32, ES=3, FRAC_W=26):
- 1.0+1.0 (scale 0, frac 0; in_sub=0), out_ready=1 → after 4 cycles: out_sum scale=1, frac=0, sgn=0, tag echoed.
- 1.0−0.75 (0.75 = scale −1, frac MSB=1; in_sub=1) → scale=−2, frac=0, sgn=0. Then 1.5−1.5 → zero=1, sgn=0, scale=0.
- 2^100 + 1.0 → scale=100, frac=0. With POSIT_ADD_STICKY_EN, out_sticky=1; without it, out_sticky=0.
- inf + 1.0, and 0 + (−3.0) → first gives inf=1, zero=0; second gives sgn=1, scale=1, frac=`10…0`.
- 6 back-to-back ops (tags 0–5), out_ready held low for 3 cycles mid-stream → in_ready falls with the stall, no op lost or duplicated, tags emerge 0–5 in order, out_sum stable while stalled.
- rst_n pulsed low with 3 ops in flight → out_valid=0 immediately (asynchronous). No stale result emerges after release; a fresh op completes in 4 cycles.
